// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: small circular FIFO between the ALU and the writeback port.
// Captures each ALU result (transaction ID, result, branch result) and
// presents the oldest buffered entry to writeback with one cycle of latency.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   flush_i                drop every buffered entry at the next edge
//   alu_valid_i            ALU result valid; pushed when alu_ready_o is high
//   alu_trans_id_i         ALU transaction ID
//   alu_result_i           ALU result (XLEN bits)
//   alu_branch_res_i       ALU branch result
//   alu_ready_o            buffer has a free entry (registered state only)
//   wb_valid_o             head entry valid
//   wb_trans_id_o          head entry transaction ID
//   wb_result_o            head entry result
//   wb_branch_res_o        head entry branch result
//   wb_ready_i             writeback takes the head entry this cycle
//   count_o                current occupancy
//
// CVA6Cfg and XLEN stand in for the core configuration and riscv::XLEN so this
// file elaborates stand-alone; XLEN must match the core's register width.
module alu_wb_buffer #(
  parameter int unsigned CVA6Cfg       = 0,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       alu_valid_i,
  input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
  input  logic [XLEN-1:0]            alu_result_i,
  input  logic                       alu_branch_res_i,
  output logic                       alu_ready_o,
  output logic                       wb_valid_o,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [XLEN-1:0]            wb_result_o,
  output logic                       wb_branch_res_o,
  input  logic                       wb_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic unused_cfg;
  assign unused_cfg = |CVA6Cfg;

  logic [PtrW-1:0]          wptr_q, wptr_d;
  logic [PtrW-1:0]          rptr_q, rptr_d;
  logic [CntW-1:0]          count_q, count_d;
  logic [TRANS_ID_BITS-1:0] id_q  [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_d  [DEPTH];
  logic [XLEN-1:0]          res_q [DEPTH];
  logic [XLEN-1:0]          res_d [DEPTH];
  logic [DEPTH-1:0]         br_q, br_d;

  logic push, pop;

  // Ready and valid come from the registered count only, so there is no
  // combinational path from wb_ready_i to alu_ready_o; a full buffer refuses
  // a push even when the head is popped in the same cycle.
  assign alu_ready_o     = (count_q < CntW'(DEPTH));
  assign wb_valid_o      = (count_q != '0);
  assign wb_trans_id_o   = id_q[rptr_q];
  assign wb_result_o     = res_q[rptr_q];
  assign wb_branch_res_o = br_q[rptr_q];
  assign count_o         = count_q;

  assign push = alu_valid_i & alu_ready_o;
  assign pop  = wb_valid_o & wb_ready_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    id_d    = id_q;
    res_d   = res_q;
    br_d    = br_q;
    if (flush_i) begin
      // Flush wins over any push or pop presented in the same cycle.
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        id_d[wptr_q]  = alu_trans_id_i;
        res_d[wptr_q] = alu_result_i;
        br_d[wptr_q]  = alu_branch_res_i;
        wptr_d        = wptr_q + PtrW'(1);  // DEPTH is a power of two: natural wrap
      end
      if (pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      id_q    <= '{default: '0};
      res_q   <= '{default: '0};
      br_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      id_q    <= id_d;
      res_q   <= res_d;
      br_q    <= br_d;
    end
  end

endmodule
